// File: rtl/tap_debounce_pkg.sv
// Shared FSM state encodings and the pin polarity helper for the tap_debounce block.
package tap_debounce_pkg;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] PRESSED = 2'd1;
  localparam logic [1:0] LONG    = 2'd2;

  // Maps a raw pin level onto "1 = pressed" for either board wiring.
  function automatic logic normalisePin(input logic pin, input logic activeLow);
    return activeLow ? ~pin : pin;
  endfunction

endpackage

// File: rtl/tap_debounce_cdc_sync.sv
// Generic single-bit synchroniser; the reset value lets callers preload an idle level.
module tap_debounce_cdc_sync #(
  parameter int STAGES = 2,
  parameter bit INIT   = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= {STAGES{INIT}};
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/tap_debounce.sv
// Strobe-sampled button debouncer with press/release pulses and long-press detection.
module tap_debounce
  import tap_debounce_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int NSAMPLES    = 4,
  parameter int LONG_TICKS  = 16,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_strobe,
  input  logic i_btn_in,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_long_press,
  output logic o_long_held
);

  localparam int CW = $clog2(LONG_TICKS + 1);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_TICKS - 1);
  localparam logic [CW-1:0] LONG_MAX  = CW'(LONG_TICKS);

  logic                w_sync;
  logic                w_s;
  logic [NSAMPLES-1:0] w_nh;
  logic                w_all_ones;
  logic                w_all_zeros;

  logic [1:0]          r_state;
  logic [CW-1:0]       r_cnt;
  logic [NSAMPLES-1:0] r_hist;
  logic                r_level;
  logic                r_press;
  logic                r_release;
  logic                r_long_press;
  logic                r_long_held;

  // Preloading the released level keeps a button held through reset from looking like an instant press.
  tap_debounce_cdc_sync #(
    .STAGES (SYNC_STAGES),
    .INIT   (ACTIVE_LOW)
  ) u_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_btn_in),
    .o_q   (w_sync)
  );

  assign w_s         = normalisePin(w_sync, ACTIVE_LOW);
  assign w_nh        = {r_hist[NSAMPLES-2:0], w_s};
  assign w_all_ones  = &w_nh;
  assign w_all_zeros = ~|w_nh;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_hist       <= '0;
      r_level      <= 1'b0;
      r_press      <= 1'b0;
      r_release    <= 1'b0;
      r_long_press <= 1'b0;
      r_long_held  <= 1'b0;
    end else begin
      r_press      <= 1'b0;
      r_release    <= 1'b0;
      r_long_press <= 1'b0;
      if (i_strobe) begin
        r_hist <= w_nh;
        case (r_state)
          IDLE: begin
            if (w_all_ones) begin
              r_state <= PRESSED;
              r_level <= 1'b1;
              r_press <= 1'b1;
              r_cnt   <= '0;
            end
          end
          PRESSED: begin
            // Saturating count; a release on the threshold strobe wins over long_press.
            if (r_cnt != LONG_MAX) r_cnt <= r_cnt + CW'(1);
            if (w_all_zeros) begin
              r_state   <= IDLE;
              r_level   <= 1'b0;
              r_release <= 1'b1;
            end else if (r_cnt == LONG_LAST) begin
              r_state      <= LONG;
              r_long_press <= 1'b1;
              r_long_held  <= 1'b1;
            end
          end
          LONG: begin
            if (w_all_zeros) begin
              r_state     <= IDLE;
              r_level     <= 1'b0;
              r_release   <= 1'b1;
              r_long_held <= 1'b0;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign o_level      = r_level;
  assign o_press      = r_press;
  assign o_release    = r_release;
  assign o_long_press = r_long_press;
  assign o_long_held  = r_long_held;

endmodule

// File: tb/tb_tap_debounce.sv
// Directed bench for tap_debounce: a run-length reference model feeds an expected-output queue.
module tb_tap_debounce;

  localparam int NS = 4;
  localparam int LT = 8;

  logic i_clk = 1'b0;
  logic i_rst, i_strobe, i_btn_in;
  logic o_level, o_press, o_release, o_long_press, o_long_held;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [4:0] expQ[$];

  logic mSync0, mSync1, mLevel, mHeld;
  int   runOnes, runZeros, mState, mCnt;

  int pressCount, releaseCount, longCount;
  int lastPressAt, lastReleaseAt, lastLongAt;

  tap_debounce #(
    .SYNC_STAGES (2),
    .NSAMPLES    (NS),
    .LONG_TICKS  (LT),
    .ACTIVE_LOW  (1'b1)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_strobe     (i_strobe),
    .i_btn_in     (i_btn_in),
    .o_level      (o_level),
    .o_press      (o_press),
    .o_release    (o_release),
    .o_long_press (o_long_press),
    .o_long_held  (o_long_held)
  );

  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  // Reference model: stability is tracked as run lengths of equal samples, state as plain ints.
  function automatic logic [4:0] modelStep(input logic r, input logic st, input logic b);
    logic s, pr, rl, lp;
    pr = 1'b0; rl = 1'b0; lp = 1'b0;
    if (r) begin
      mSync0 = 1'b1; mSync1 = 1'b1;
      runOnes = 0; runZeros = NS;
      mState = 0; mCnt = 0; mLevel = 1'b0; mHeld = 1'b0;
    end else begin
      s = ~mSync1;
      mSync1 = mSync0;
      mSync0 = b;
      if (st) begin
        if (s) begin runOnes = (runOnes < NS) ? runOnes + 1 : NS; runZeros = 0; end
        else   begin runZeros = (runZeros < NS) ? runZeros + 1 : NS; runOnes = 0; end
        if (mState == 0) begin
          if (runOnes >= NS) begin mState = 1; mLevel = 1'b1; pr = 1'b1; mCnt = 0; end
        end else if (mState == 1) begin
          if (runZeros >= NS) begin mState = 0; mLevel = 1'b0; rl = 1'b1; end
          else if (mCnt == LT - 1) begin mState = 2; lp = 1'b1; mHeld = 1'b1; end
          if (mCnt < LT) mCnt++;
        end else begin
          if (runZeros >= NS) begin mState = 0; mLevel = 1'b0; rl = 1'b1; mHeld = 1'b0; end
        end
      end
    end
    return {mLevel, pr, rl, lp, mHeld};
  endfunction

  task automatic applyStimulus(input logic r, input logic b, input int n);
    logic [4:0] obs;
    for (int k = 0; k < n; k++) begin
      @(negedge i_clk);
      i_rst    = r;
      i_btn_in = b;
      i_strobe = ((cyc % 10) == 9);
      expQ.push_back(modelStep(r, i_strobe, b));
      @(posedge i_clk);
      #1;
      obs = {o_level, o_press, o_release, o_long_press, o_long_held};
      checkOutput("outputs{lvl,prs,rel,lp,held}", 32'(obs), 32'(expQ.pop_front()));
      if (o_press)      begin pressCount++;   lastPressAt   = cyc; end
      if (o_release)    begin releaseCount++; lastReleaseAt = cyc; end
      if (o_long_press) begin longCount++;    lastLongAt    = cyc; end
      cyc++;
    end
  endtask

  task automatic clearCounts();
    pressCount = 0; releaseCount = 0; longCount = 0;
    lastPressAt = -1; lastReleaseAt = -1; lastLongAt = -1;
  endtask

  initial begin
    i_rst = 1'b1; i_btn_in = 1'b1; i_strobe = 1'b0;
    clearCounts();

    $display("[TB] reset with button released");
    applyStimulus(1'b1, 1'b1, 50);
    checkOutput("reset_pulses", 32'(pressCount + releaseCount + longCount), 0);
    checkOutput("reset_level", 32'(o_level), 0);
    checkOutput("reset_held", 32'(o_long_held), 0);

    $display("[TB] press held 100 clk");
    clearCounts();
    applyStimulus(1'b0, 1'b0, 100);
    checkOutput("p2_press_count", 32'(pressCount), 1);
    checkOutput("p2_press_at", 32'(lastPressAt), 89);
    checkOutput("p2_level", 32'(o_level), 1);
    checkOutput("p2_long_count", 32'(longCount), 0);

    $display("[TB] slow release crossing long threshold");
    clearCounts();
    applyStimulus(1'b0, 1'b1, 70);
    checkOutput("p3a_long_at", 32'(lastLongAt), 169);
    checkOutput("p3a_release_at", 32'(lastReleaseAt), 189);
    checkOutput("p3a_release_count", 32'(releaseCount), 1);
    checkOutput("p3a_held", 32'(o_long_held), 0);

    $display("[TB] glitching input");
    clearCounts();
    for (int i = 0; i < 200; i++) applyStimulus(1'b0, ((i / 7) % 2) == 1, 1);
    checkOutput("glitch_press_count", 32'(pressCount), 0);
    checkOutput("glitch_release_count", 32'(releaseCount), 0);
    checkOutput("glitch_level", 32'(o_level), 0);

    $display("[TB] long press then release");
    clearCounts();
    applyStimulus(1'b0, 1'b1, 30);
    applyStimulus(1'b0, 1'b0, 150);
    checkOutput("long_press_at", 32'(lastPressAt), 489);
    checkOutput("long_at", 32'(lastLongAt), 569);
    checkOutput("long_count", 32'(longCount), 1);
    checkOutput("long_held_on", 32'(o_long_held), 1);
    clearCounts();
    applyStimulus(1'b0, 1'b1, 60);
    checkOutput("long_release_at", 32'(lastReleaseAt), 639);
    checkOutput("long_release_count", 32'(releaseCount), 1);
    checkOutput("long_release_level", 32'(o_level), 0);
    checkOutput("long_release_held", 32'(o_long_held), 0);

    $display("[TB] release completing on threshold strobe");
    clearCounts();
    applyStimulus(1'b0, 1'b0, 80);
    applyStimulus(1'b0, 1'b1, 60);
    checkOutput("tie_press_at", 32'(lastPressAt), 699);
    checkOutput("tie_release_at", 32'(lastReleaseAt), 779);
    checkOutput("tie_long_count", 32'(longCount), 0);

    $display("[TB] reset during long hold");
    clearCounts();
    applyStimulus(1'b0, 1'b0, 130);
    checkOutput("mid_long_at", 32'(lastLongAt), 919);
    checkOutput("mid_held", 32'(o_long_held), 1);
    applyStimulus(1'b1, 1'b0, 1);
    checkOutput("mid_rst_level", 32'(o_level), 0);
    checkOutput("mid_rst_held", 32'(o_long_held), 0);
    clearCounts();
    applyStimulus(1'b0, 1'b0, 60);
    checkOutput("refire_press_at", 32'(lastPressAt), 969);
    checkOutput("refire_press_count", 32'(pressCount), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
